// File: rtl/collision_monitor.sv
// Per-frame collision detector tapping the VGA pixel stream; reports one event per hit frame.
// Optional off-road detection is enabled by defining COLLISION_OFFROAD_EN.
module collision_monitor #(
  parameter int unsigned H_VIS = 640,
  parameter int unsigned V_VIS = 480,
  parameter int unsigned N_OBS = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_tick,
  input  logic             video_on,
  input  logic [9:0]       pixel_x,
  input  logic [9:0]       pixel_y,
  input  logic             on_player,
  input  logic [N_OBS-1:0] on_obs,
  input  logic             off_road,
  output logic             evt_valid,
  output logic [N_OBS-1:0] evt_mask,
  output logic             evt_offroad,
  output logic [9:0]       evt_x,
  output logic [9:0]       evt_y,
  input  logic             evt_ack,
  output logic [7:0]       drop_cnt
);

  localparam logic SCAN   = 1'b0;
  localparam logic REPORT = 1'b1;

  logic             state_q, state_d;
  logic [N_OBS-1:0] evt_mask_q, evt_mask_d;
  logic             evt_off_q, evt_off_d;
  logic [9:0]       evt_x_q, evt_x_d, evt_y_q, evt_y_d;
  logic [7:0]       drop_q, drop_d;
  logic [N_OBS-1:0] acc_mask_q, acc_mask_d;
  logic             acc_off_q, acc_off_d;
  logic             acc_first_q, acc_first_d;
  logic [9:0]       acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic             discard_q, discard_d;

  logic             s, hit, fe, fe_hit, h_off;
  logic [N_OBS-1:0] h_obs;
  logic [N_OBS-1:0] m_mask;
  logic             m_off;
  logic [9:0]       m_x, m_y;

`ifdef COLLISION_OFFROAD_EN
  assign h_off = on_player & off_road;
`else
  logic unused_off_road;
  assign unused_off_road = off_road;
  assign h_off = 1'b0;
`endif

  always_comb begin
    s      = pix_tick & video_on;
    h_obs  = on_obs & {N_OBS{on_player}};
    hit    = (|h_obs) | h_off;
    fe     = s && (pixel_x == 10'(H_VIS - 1)) && (pixel_y == 10'(V_VIS - 1));
    // Merged view includes the current pixel so the last pixel's hits count in its own frame.
    m_mask = acc_mask_q | h_obs;
    m_off  = acc_off_q | h_off;
    m_x    = acc_first_q ? acc_x_q : pixel_x;
    m_y    = acc_first_q ? acc_y_q : pixel_y;
    fe_hit = fe & ((|m_mask) | m_off) & ~discard_q;
  end

  always_comb begin
    acc_mask_d  = acc_mask_q;
    acc_off_d   = acc_off_q;
    acc_first_d = acc_first_q;
    acc_x_d     = acc_x_q;
    acc_y_d     = acc_y_q;
    discard_d   = discard_q;
    if (s) begin
      acc_mask_d = acc_mask_q | h_obs;
      acc_off_d  = acc_off_q | h_off;
      if (hit && !acc_first_q) begin
        acc_x_d     = pixel_x;
        acc_y_d     = pixel_y;
        acc_first_d = 1'b1;
      end
    end
    if (fe) begin
      acc_mask_d  = '0;
      acc_off_d   = 1'b0;
      acc_first_d = 1'b0;
      acc_x_d     = '0;
      acc_y_d     = '0;
      discard_d   = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    evt_mask_d = evt_mask_q;
    evt_off_d  = evt_off_q;
    evt_x_d    = evt_x_q;
    evt_y_d    = evt_y_q;
    drop_d     = drop_q;
    if (fe_hit && (state_q == SCAN || evt_ack)) begin
      state_d    = REPORT;
      evt_mask_d = m_mask;
      evt_off_d  = m_off;
      evt_x_d    = m_x;
      evt_y_d    = m_y;
    end else if (fe_hit) begin
      // Pending event not yet consumed: new one is lost.
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end else if (state_q == REPORT && evt_ack) begin
      state_d = SCAN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SCAN;
      evt_mask_q  <= '0;
      evt_off_q   <= 1'b0;
      evt_x_q     <= '0;
      evt_y_q     <= '0;
      drop_q      <= '0;
      acc_mask_q  <= '0;
      acc_off_q   <= 1'b0;
      acc_first_q <= 1'b0;
      acc_x_q     <= '0;
      acc_y_q     <= '0;
      discard_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      evt_mask_q  <= evt_mask_d;
      evt_off_q   <= evt_off_d;
      evt_x_q     <= evt_x_d;
      evt_y_q     <= evt_y_d;
      drop_q      <= drop_d;
      acc_mask_q  <= acc_mask_d;
      acc_off_q   <= acc_off_d;
      acc_first_q <= acc_first_d;
      acc_x_q     <= acc_x_d;
      acc_y_q     <= acc_y_d;
      discard_q   <= discard_d;
    end
  end

  assign evt_valid   = state_q;
  assign evt_mask    = evt_mask_q;
  assign evt_offroad = evt_off_q;
  assign evt_x       = evt_x_q;
  assign evt_y       = evt_y_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_collision_monitor.sv
// Directed bench for collision_monitor: sparse pixel streams drive each frame to its end pixel.
module tb_collision_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_tick, video_on, on_player, off_road, evt_ack;
  logic [9:0] pixel_x, pixel_y;
  logic [5:0] on_obs;
  logic       evt_valid, evt_offroad;
  logic [5:0] evt_mask;
  logic [9:0] evt_x, evt_y;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  collision_monitor #(.H_VIS(640), .V_VIS(480), .N_OBS(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_tick   (pix_tick),
    .video_on   (video_on),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .on_player  (on_player),
    .on_obs     (on_obs),
    .off_road   (off_road),
    .evt_valid  (evt_valid),
    .evt_mask   (evt_mask),
    .evt_offroad(evt_offroad),
    .evt_x      (evt_x),
    .evt_y      (evt_y),
    .evt_ack    (evt_ack),
    .drop_cnt   (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; returns #1 after the rising edge with inputs idled.
  task automatic cyc(input logic [9:0] x, input logic [9:0] y, input logic pl,
                     input logic [5:0] ob, input logic off, input logic ack,
                     input logic tick, input logic vo);
    @(negedge clk);
    pix_tick = tick; video_on = vo; pixel_x = x; pixel_y = y;
    on_player = pl; on_obs = ob; off_road = off; evt_ack = ack;
    @(posedge clk);
    #1;
    pix_tick = 1'b0; video_on = 1'b0; on_player = 1'b0; on_obs = '0;
    off_road = 1'b0; evt_ack = 1'b0;
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic pl,
                     input logic [5:0] ob, input logic off);
    cyc(x, y, pl, ob, off, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic frame_end(input logic ack);
    cyc(10'd639, 10'd479, 1'b0, 6'd0, 1'b0, ack, 1'b1, 1'b1);
  endtask

  task automatic ack_only();
    cyc(10'd0, 10'd0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    pix_tick = 0; video_on = 0; pixel_x = 0; pixel_y = 0;
    on_player = 0; on_obs = 0; off_road = 0; evt_ack = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", evt_valid, 0);
    chk("rst_mask", evt_mask, 0);
    chk("rst_off", evt_offroad, 0);
    chk("rst_x", evt_x, 0);
    chk("rst_y", evt_y, 0);
    chk("rst_drop", drop_cnt, 0);
    @(negedge clk);
    reset = 1'b1;

    // First frame after reset is discarded
    pix(10'd100, 10'd200, 1'b1, 6'b000100, 1'b0);
    frame_end(1'b0);
    chk("discard_valid", evt_valid, 0);

    pix(10'd100, 10'd200, 1'b1, 6'b000100, 1'b0);
    chk("pre_fe_valid", evt_valid, 0);
    frame_end(1'b0);
    chk("f2_valid", evt_valid, 1);
    chk("f2_mask", evt_mask, 6'b000100);
    chk("f2_x", evt_x, 100);
    chk("f2_y", evt_y, 200);
    chk("f2_off", evt_offroad, 0);
    ack_only();
    chk("ack_valid", evt_valid, 0);

    // Two obstacles; obstacle without player and a blanked pixel must not count
    pix(10'd20, 10'd5, 1'b0, 6'b010000, 1'b0);
    pix(10'd50, 10'd10, 1'b1, 6'b000001, 1'b0);
    pix(10'd300, 10'd400, 1'b1, 6'b100000, 1'b0);
    cyc(10'd639, 10'd479, 1'b1, 6'b000010, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("blank_no_fe", evt_valid, 0);
    frame_end(1'b0);
    chk("two_valid", evt_valid, 1);
    chk("two_mask", evt_mask, 6'b100001);
    chk("two_x", evt_x, 50);
    chk("two_y", evt_y, 10);

    // Pending event: further hitting frames are dropped
    for (int i = 0; i < 3; i++) begin
      pix(10'd1, 10'd1, 1'b1, 6'b000010, 1'b0);
      frame_end(1'b0);
    end
    chk("drop3", drop_cnt, 3);
    chk("drop3_mask", evt_mask, 6'b100001);
    chk("drop3_x", evt_x, 50);
    chk("drop3_y", evt_y, 10);
    frame_end(1'b0);
    chk("nohit_nodrop", drop_cnt, 3);
    for (int i = 0; i < 297; i++) cyc(10'd639, 10'd479, 1'b1, 6'b000010, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("drop_sat", drop_cnt, 255);
    chk("drop_sat_valid", evt_valid, 1);

    // Ack coincident with a frame end that hits on its last pixel
    cyc(10'd639, 10'd479, 1'b1, 6'b001000, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("b2b_valid", evt_valid, 1);
    chk("b2b_x", evt_x, 639);
    chk("b2b_y", evt_y, 479);
    chk("b2b_mask", evt_mask, 6'b001000);
    chk("b2b_drop", drop_cnt, 255);
    ack_only();
    chk("b2b_ack", evt_valid, 0);

    // Hits without pix_tick are not sampled
    cyc(10'd3, 10'd3, 1'b1, 6'b000001, 1'b0, 1'b0, 1'b0, 1'b1);
    frame_end(1'b0);
    chk("notick_valid", evt_valid, 0);

    // Off-road only
    pix(10'd5, 10'd5, 1'b1, 6'b000000, 1'b1);
    frame_end(1'b0);
`ifdef COLLISION_OFFROAD_EN
    chk("off_valid", evt_valid, 1);
    chk("off_flag", evt_offroad, 1);
    chk("off_mask", evt_mask, 0);
    chk("off_x", evt_x, 5);
    ack_only();
`else
    chk("off_valid", evt_valid, 0);
    chk("off_flag", evt_offroad, 0);
`endif

    // Asynchronous reset while an event is pending and a frame is in progress
    pix(10'd7, 10'd8, 1'b1, 6'b000010, 1'b0);
    frame_end(1'b0);
    chk("pre_rst_valid", evt_valid, 1);
    pix(10'd20, 10'd20, 1'b1, 6'b000001, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", evt_valid, 0);
    chk("arst_mask", evt_mask, 0);
    chk("arst_x", evt_x, 0);
    chk("arst_y", evt_y, 0);
    chk("arst_drop", drop_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    pix(10'd30, 10'd30, 1'b1, 6'b000001, 1'b0);
    frame_end(1'b0);
    chk("partial_discard", evt_valid, 0);
    pix(10'd40, 10'd41, 1'b1, 6'b000001, 1'b0);
    frame_end(1'b0);
    chk("post_valid", evt_valid, 1);
    chk("post_x", evt_x, 40);
    chk("post_y", evt_y, 41);
    chk("post_mask", evt_mask, 6'b000001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/collision_monitor.md
# collision_monitor

Per-frame collision detector for the RoadFight display path. The graphics path turns game state into pixels; this block taps the same pixel stream to recover game events from it. Each frame it samples the per-pixel object coverage flags and finds pixels where the player car overlaps an obstacle car or leaves the road. At the end of each visible frame it reports one collision event to the game logic through a valid/ack handshake.

## Interface

Parameters:
- H_VIS, 640: visible pixels per line.
- V_VIS, 480: visible lines per frame.
- N_OBS, 6: number of obstacle coverage inputs.

Ports:
- clk  input  1  system clock, the same clock that drives vga_sync.
- reset  input  1  asynchronous, active-low reset.
- pix_tick  input  1  pixel-enable strobe (vga_sync p_tick); all inputs below are sampled only when this is 1.
- video_on  input  1  visible-area flag from vga_sync.
- pixel_x  input  10  current pixel column.
- pixel_y  input  10  current pixel row.
- on_player  input  1  player car covers the current pixel.
- on_obs  input  N_OBS  bit i is 1 when obstacle i is active and covers the current pixel (already ANDed with obstacle_on).
- off_road  input  1  the current pixel is outside the road surface.
- evt_valid  output  1  a collision event is pending.
- evt_mask  output  N_OBS  obstacles hit during the reported frame.
- evt_offroad  output  1  the player covered an off-road pixel during the reported frame.
- evt_x  output  10  column of the first hit pixel in raster order.
- evt_y  output  10  row of the first hit pixel in raster order.
- evt_ack  input  1  the consumer accepts the event; only meaningful while evt_valid is 1.
- drop_cnt  output  8  saturating count of events lost because evt_valid was still pending.

## Operation

- Sample qualifier: `s = pix_tick & video_on`.
- Per-pixel hit vector: `h_obs = on_obs & {N_OBS{on_player}}`; `h_off = on_player & off_road`; `hit = |h_obs | h_off`.
- Accumulators:
  - acc_mask, acc_off, acc_first, acc_x, acc_y.
  - On `s`, OR h_obs into acc_mask and h_off into acc_off.
  - On `s & hit & !acc_first`, capture pixel_x and pixel_y into acc_x and acc_y, then set acc_first.
- Frame end: `fe = s & pixel_x==H_VIS-1 & pixel_y==V_VIS-1`.
  - The last pixel's hits are merged into the frame result in the same cycle.
  - All accumulators clear on `fe`.
- States:
  - SCAN: no event pending.
  - REPORT: event pending.
- Transitions:
  - SCAN → REPORT on `fe` with a non-zero merged result. The evt_* registers load the merged values.
  - REPORT → SCAN on `evt_ack` when there is no `fe` with hits in the same cycle.
  - REPORT with `evt_ack` and `fe`-with-hits in the same cycle: the new event loads and the block stays in REPORT. evt_valid stays 1, which gives back-to-back events.
  - REPORT with `fe`-with-hits and no `evt_ack`: the new event is discarded, drop_cnt increments (saturating at 255), and the evt_* outputs are unchanged.
- A frame with no hits generates no event and leaves the state unchanged.
- pixel_x and pixel_y are 10-bit unsigned. Coordinates are compared against H_VIS-1 and V_VIS-1 only when video_on is 1.
- A frame is reported only if it was observed from its first visible pixel. Any frame in progress when reset is released is discarded.

## Timing

- Reset values:
  - state = SCAN.
  - evt_valid = 0, evt_mask = 0, evt_offroad = 0, evt_x = 0, evt_y = 0, drop_cnt = 0.
  - All accumulators = 0.
  - discard flag = 1 (set on reset, cleared on the first `fe`).
- Event latency: evt_valid rises on the clk edge that ends the `fe` cycle, i.e. one clock after the last visible pixel is sampled.
- evt_valid falls on the clock after the `evt_ack` cycle, unless the simultaneous case above applies.
- Every evt_* output is registered and stable for as long as evt_valid is 1.
- Reset asserted mid-frame or mid-REPORT clears everything asynchronously. No event is produced for the interrupted frame.
- When pix_tick is 0, no accumulator, state or output changes, except for handshake completion via evt_ack.

## Configuration

- `COLLISION_OFFROAD_EN` defined: off-road detection is active as described above.
- `COLLISION_OFFROAD_EN` undefined:
  - The off_road port is still present but ignored.
  - h_off is tied to 0 and evt_offroad is constant 0.
  - Only car-to-car overlaps generate events.

## Test plan

- Release reset, then run a full frame with on_player=1 and on_obs=6'b000100 only at pixel (100,200), never acked. Expected: the discarded first frame produces nothing. On the second frame, one clock after (639,479), evt_valid=1, evt_mask=000100, evt_x=100, evt_y=200, evt_offroad=0.
- Player overlaps obstacle 0 at (50,10) and obstacle 5 at (300,400) in the same frame. Expected: evt_mask=100001, evt_x=50, evt_y=10.
- Leave an event pending with no ack for 3 further hitting frames. Expected: drop_cnt=3 and evt_* still hold the first frame's values. Force 300 drops and expect drop_cnt=255.
- Assert evt_ack in the same cycle as `fe` of a frame with a hit at (639,479). Expected: evt_valid stays 1 and evt_x=639, evt_y=479 next clock.
- on_player=1 with off_road=1 at (5,5), no obstacles. Expected with `COLLISION_OFFROAD_EN` defined: evt_offroad=1, evt_mask=0. Expected without it: no event.
- Pull reset low mid-frame after a hit at (20,20), then release it. Expected: all outputs are 0 immediately and no event is reported for the interrupted frame or the next partial frame.
